// File: rtl/fft_addr_gen.sv
// Radix-2 FFT butterfly address generator.
// Walks LOG2N stages of N/2 butterflies each. For every butterfly it presents
// the two sample addresses and the twiddle exponent through a valid/ready
// handshake. Optional idle gaps separate the stages. All outputs come straight
// from flops, so there is no combinational path from out_ready to any output.
module fft_addr_gen #(
   parameter int LOG2N     = 5,
   parameter int STAGE_GAP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             inv,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-1:0] n,
   output logic [2:0]       stage,
   output logic             e_start,
   output logic             inv_o,
   output logic             busy,
   output logic             done
);

   localparam int               JW       = LOG2N - 1;
   localparam logic [JW-1:0]    J_ZERO   = JW'(1'b0);
   localparam logic [JW-1:0]    J_ONE    = JW'(1'b1);
   localparam logic [JW-1:0]    J_LAST   = {JW{1'b1}};
   localparam logic [2:0]       S_LAST   = 3'(LOG2N - 1);
   localparam logic [3:0]       GAP_LOAD = 4'(STAGE_GAP - 1);
   localparam logic [LOG2N-1:0] A_ONE    = LOG2N'(1'b1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;

   state_t           state_q, state_d;
   logic [JW-1:0]    j_q, j_d;
   logic [2:0]       stage_q, stage_d;
   logic [3:0]       gap_q, gap_d;
   logic             valid_q, valid_d;
   logic             estart_q, estart_d;
   logic             inv_q, inv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LOG2N-1:0] addr_a_q, addr_a_d;
   logic [LOG2N-1:0] addr_b_q, addr_b_d;
   logic [LOG2N-1:0] n_q, n_d;

   // Upper-leg address: group index moved up one bit past the half span,
   // position within the group kept in the low s bits.
   function automatic logic [LOG2N-1:0] calc_addr_a(input logic [2:0] s, input logic [JW-1:0] jj);
      logic [LOG2N-1:0] jx;
      logic [LOG2N-1:0] mask;
      jx   = {1'b0, jj};
      mask = ~({LOG2N{1'b1}} << s);
      return (((jx >> s) << (s + 3'd1)) | (jx & mask));
   endfunction

   // Twiddle exponent: position within the group scaled to the N-point circle.
   function automatic logic [LOG2N-1:0] calc_n(input logic [2:0] s, input logic [JW-1:0] jj);
      logic [LOG2N-1:0] jx;
      logic [LOG2N-1:0] mask;
      jx   = {1'b0, jj};
      mask = ~({LOG2N{1'b1}} << s);
      return ((jx & mask) << (S_LAST - s));
   endfunction

   // Next-state logic: sequencing, handshake and next output values.
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      j_d      = j_q;
      gap_d    = gap_q;
      inv_d    = inv_q;
      valid_d  = 1'b0;
      estart_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      n_d      = n_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d  = ISSUE;
               stage_d  = 3'd0;
               j_d      = J_ZERO;
               inv_d    = inv;
               busy_d   = 1'b1;
               valid_d  = 1'b1;
               estart_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            busy_d   = 1'b1;
            valid_d  = 1'b1;
            estart_d = estart_q;
            if (out_ready) begin
               estart_d = 1'b0;
               if (j_q == J_LAST) begin
                  j_d = J_ZERO;
                  if (stage_q == S_LAST) begin
                     state_d = FIN;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     stage_d = stage_q + 3'd1;
                     if (STAGE_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                        valid_d = 1'b0;
                     end else begin
                        state_d  = ISSUE;
                        estart_d = 1'b1;
                     end
                  end
               end else begin
                  j_d = j_q + J_ONE;
               end
            end else begin
               state_d = ISSUE;
            end
         end
         GAP: begin
            busy_d = 1'b1;
            if (gap_q == 4'd0) begin
               state_d  = ISSUE;
               valid_d  = 1'b1;
               estart_d = 1'b1;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      // Addresses only move when a butterfly is about to be presented, so
      // they hold through stalls, gaps and idle.
      if (state_d == ISSUE) begin
         addr_a_d = calc_addr_a(stage_d, j_d);
         addr_b_d = calc_addr_a(stage_d, j_d) + (A_ONE << stage_d);
         n_d      = calc_n(stage_d, j_d);
      end else begin
         addr_a_d = addr_a_q;
         addr_b_d = addr_b_q;
         n_d      = n_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         stage_q  <= 3'd0;
         j_q      <= J_ZERO;
         gap_q    <= 4'd0;
         valid_q  <= 1'b0;
         estart_q <= 1'b0;
         inv_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_a_q <= {LOG2N{1'b0}};
         addr_b_q <= {LOG2N{1'b0}};
         n_q      <= {LOG2N{1'b0}};
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         j_q      <= j_d;
         gap_q    <= gap_d;
         valid_q  <= valid_d;
         estart_q <= estart_d;
         inv_q    <= inv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         n_q      <= n_d;
      end
   end

   assign out_valid = valid_q;
   assign addr_a    = addr_a_q;
   assign addr_b    = addr_b_q;
   assign n         = n_q;
   assign stage     = stage_q;
   assign e_start   = estart_q;
   assign inv_o     = inv_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: stimulus pushes the expected butterfly
// stream, a negedge monitor pops and compares on each handshake.
module tb_fft_addr_gen;

   localparam int LOG2N = 5;
   localparam int N     = 32;
   localparam int HALFN = 16;
   localparam int TOTAL = 80;
   localparam int GAP   = 2;

   logic       clk = 1'b0;
   logic       reset, start, inv, out_ready;
   logic       out_valid, e_start, inv_o, busy, done;
   logic [4:0] addr_a, addr_b, n;
   logic [2:0] stage;

   logic       start0, rdy0, inv0;
   logic       out_valid0, e_start0, inv_o0, busy0, done0;
   logic [4:0] addr_a0, addr_b0, n0;
   logic [2:0] stage0;

   assign rdy0 = 1'b1;
   assign inv0 = 1'b0;

   always #5 clk = ~clk;

   fft_addr_gen #(.LOG2N(LOG2N), .STAGE_GAP(GAP)) u_dut (
      .clk(clk), .reset(reset), .start(start), .inv(inv), .out_ready(out_ready),
      .out_valid(out_valid), .addr_a(addr_a), .addr_b(addr_b), .n(n), .stage(stage),
      .e_start(e_start), .inv_o(inv_o), .busy(busy), .done(done));

   fft_addr_gen #(.LOG2N(LOG2N), .STAGE_GAP(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .inv(inv0), .out_ready(rdy0),
      .out_valid(out_valid0), .addr_a(addr_a0), .addr_b(addr_b0), .n(n0), .stage(stage0),
      .e_start(e_start0), .inv_o(inv_o0), .busy(busy0), .done(done0));

   typedef struct packed {
      logic [2:0] stg;
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] tw;
      logic       es;
      logic       iv;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected stream built group by group: base steps by twice the half span.
   task automatic push_transform(input logic iv);
      exp_t e;
      for (int s = 0; s < LOG2N; s++) begin
         int half;
         half = 1 << s;
         for (int base = 0; base < N; base += 2 * half) begin
            for (int p = 0; p < half; p++) begin
               e.stg = 3'(s);
               e.a   = 5'(base + p);
               e.b   = 5'(base + p + half);
               e.tw  = 5'(p * (N / (2 * half)));
               e.es  = (base == 0 && p == 0);
               e.iv  = iv;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   // Monitor for the gapped instance.
   int         xfer_cnt = 0;
   int         gap_cnt  = 0;
   bit         in_gap   = 1'b0;
   bit         exp_done = 1'b0;
   bit         frz_ok   = 1'b0;
   logic [19:0] frz;
   always @(negedge clk) begin
      if (!reset) begin
         xfer_cnt = 0;
         in_gap   = 1'b0;
         exp_done = 1'b0;
         frz_ok   = 1'b0;
      end else begin
         if (exp_done) begin
            check("done_after_last", 32'({done, out_valid, busy}), 32'(3'b101));
            exp_done = 1'b0;
         end
         if (frz_ok && out_valid)
            check("stall_hold", 32'({stage, addr_a, addr_b, n, e_start, inv_o}), 32'(frz));
         frz_ok = 1'b0;
         if (in_gap) begin
            if (out_valid) begin
               check("gap_len", 32'(gap_cnt), 32'(GAP));
               in_gap = 1'b0;
            end else begin
               gap_cnt++;
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_xfer: got stage %0d addr_a %0d with empty scoreboard", stage, addr_a);
            end else begin
               exp_t e;
               int   jj, ss;
               e = exp_q.pop_front();
               check("xfer", 32'({stage, addr_a, addr_b, n, e_start, inv_o}), 32'(e));
               jj = xfer_cnt % HALFN;
               ss = xfer_cnt / HALFN;
               if (ss == 0 && jj == 0) check("s0j0", 32'({addr_a, addr_b, n, e_start}), 32'({5'd0, 5'd1, 5'd0, 1'b1}));
               if (ss == 4 && jj == 5) check("s4j5", 32'({addr_a, addr_b, n}), 32'({5'd5, 5'd21, 5'd5}));
               if (ss == 2 && jj == 5) check("s2j5", 32'({addr_a, addr_b, n}), 32'({5'd9, 5'd13, 5'd4}));
               if (ss == 1 && jj == 3) check("s1j3", 32'({addr_a, addr_b, n}), 32'({5'd5, 5'd7, 5'd8}));
            end
            xfer_cnt++;
            if (xfer_cnt == TOTAL) begin
               exp_done = 1'b1;
               xfer_cnt = 0;
            end else if (xfer_cnt % HALFN == 0) begin
               in_gap  = 1'b1;
               gap_cnt = 0;
            end
         end else if (out_valid) begin
            frz_ok = 1'b1;
            frz    = {stage, addr_a, addr_b, n, e_start, inv_o};
         end
      end
   end

   // Monitor for the gapless instance.
   int cnt0    = 0;
   bit s0_pend = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         cnt0    = 0;
         s0_pend = 1'b0;
      end else begin
         if (s0_pend) begin
            check("gap0_next", 32'({out_valid0, stage0, e_start0, addr_a0, addr_b0}),
                  32'({1'b1, 3'd1, 1'b1, 5'd0, 5'd2}));
            s0_pend = 1'b0;
         end
         if (out_valid0) begin
            cnt0++;
            if (stage0 == 3'd0 && addr_a0 == 5'd30) s0_pend = 1'b1;
         end
         if (done0) begin
            check("gap0_total", 32'(cnt0), 32'(TOTAL));
            cnt0 = 0;
         end
      end
   end

   task automatic wait_done(input string nm, input bit rnd);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      end
      out_ready = 1'b1;
      check(nm, 32'(seen), 32'(1));
   endtask

   task automatic pulse_start(input logic iv);
      @(posedge clk); #1;
      start = 1'b1;
      inv   = iv;
      @(posedge clk); #1;
      start = 1'b0;
      inv   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b0; start = 1'b0; inv = 1'b0; out_ready = 1'b1; start0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vals", 32'({out_valid, busy, done, e_start, inv_o, addr_a, addr_b, n, stage}), 32'(0));
      reset = 1'b1;

      // Transform 1: free flowing, ignored start/inv mid-transform.
      push_transform(1'b0);
      pulse_start(1'b0);
      check("first_bfly", 32'({out_valid, stage, addr_a, addr_b, n, e_start, busy}),
            32'({1'b1, 3'd0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1}));
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1; inv = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0; inv = 1'b0;
      wait_done("t1_done", 1'b0);
      @(posedge clk); #1;
      check("t1_idle", 32'({busy, out_valid, done, inv_o}), 32'(0));
      check("t1_drained", 32'(exp_q.size()), 32'(0));

      // Gapless instance.
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (done0) begin seen = 1'b1; break; end
      end
      check("gap0_done", 32'(seen), 32'(1));

      // Transform 2: inverse, random backpressure, 4-cycle stall at stage 1 j=2.
      push_transform(1'b1);
      pulse_start(1'b1);
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (out_valid && stage == 3'd1 && addr_a == 5'd4) begin
            seen = 1'b1;
            break;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      check("reach_s1j2", 32'(seen), 32'(1));
      out_ready = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         check("stall_vals", 32'({out_valid, addr_a, addr_b, n}), 32'({1'b1, 5'd4, 5'd6, 5'd0}));
      end
      out_ready = 1'b1;
      wait_done("t2_done", 1'b1);
      @(posedge clk); #1;
      check("t2_idle_inv", 32'({busy, out_valid, inv_o}), 32'({1'b0, 1'b0, 1'b1}));
      check("t2_drained", 32'(exp_q.size()), 32'(0));

      // Transform 3: reset during stage 3.
      push_transform(1'b0);
      pulse_start(1'b0);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (out_valid && stage == 3'd3) begin seen = 1'b1; break; end
      end
      check("reach_s3", 32'(seen), 32'(1));
      reset = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      check("rst_mid", 32'({out_valid, busy, done, e_start, inv_o, addr_a, addr_b, n, stage}), 32'(0));
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("no_resume", 32'({out_valid, busy, done}), 32'(0));

      // Transform 4, then start held through FIN for back-to-back transform 5.
      push_transform(1'b0);
      pulse_start(1'b0);
      wait_done("t4_done", 1'b0);
      push_transform(1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      check("fin_start_ignored", 32'({busy, out_valid}), 32'(0));
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_start_taken", 32'({busy, out_valid, stage}), 32'({1'b1, 1'b1, 3'd0}));
      wait_done("t5_done", 1'b0);
      @(posedge clk); #1;
      check("t5_drained", 32'(exp_q.size()), 32'(0));

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 5, FFT size exponent (N = 2^LOG2N); legal range 2..7.
REQ-002 SHALL have parameter STAGE_GAP, default 2, idle cycles inserted between stages; legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a new transform, sampled in IDLE only.
REQ-006 SHALL have port inv  input  1  inverse-transform select, latched when start is accepted.
REQ-007 SHALL have port out_ready  input  1  downstream (angle LUT / butterfly) accepts the current butterfly.
REQ-008 SHALL have port out_valid  output  1  addr_a, addr_b, n, stage, e_start and inv_o are valid.
REQ-009 SHALL have port addr_a  output  LOG2N  upper-leg sample address.
REQ-010 SHALL have port addr_b  output  LOG2N  lower-leg sample address.
REQ-011 SHALL have port n  output  LOG2N  twiddle exponent k of W_N^k, to the angle LUT.
REQ-012 SHALL have port stage  output  3  current stage, 0..LOG2N-1.
REQ-013 SHALL have port e_start  output  1  high with the first butterfly of each stage.
REQ-014 SHALL have port inv_o  output  1  latched inv.
REQ-015 SHALL have port busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final butterfly handshake.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, GAP, FIN.
REQ-018 IDLE: start=1 -> ISSUE next cycle; stage=0, butterfly index j=0, inv latched, busy=1.
REQ-019 ISSUE: out_valid=1; a butterfly is transferred on a cycle with out_valid=1 and out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, all data outputs SHALL remain unchanged.
REQ-021 Per transfer: j increments; after j = N/2-1, j wraps to 0 and stage increments.
REQ-022 Address rule for stage s, butterfly j: half=2^s, grp=j>>s, pos=j mod half; addr_a=grp*2*half+pos; addr_b=addr_a+half; n=pos<<(LOG2N-1-s).
REQ-023 All outputs SHALL be registered; no combinational path from out_ready to any output.
REQ-024 e_start=1 only while j=0 in ISSUE.
REQ-025 After the last butterfly of a non-final stage: STAGE_GAP>0 -> GAP for exactly STAGE_GAP cycles with out_valid=0, then ISSUE; STAGE_GAP=0 -> next stage presented the following cycle without a bubble.
REQ-026 After the last butterfly of stage LOG2N-1 -> FIN: out_valid=0, done=1 for one cycle, busy=1; then IDLE, busy=0.
REQ-027 start while not in IDLE SHALL be ignored; start held high in FIN SHALL not be accepted until IDLE.
REQ-028 Total transfers per transform SHALL be LOG2N*N/2 (80 for LOG2N=5).
REQ-029 inv SHALL have no effect on addresses or n; it is forwarded on inv_o only.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE in any state, including mid-transform and mid-stall.
REQ-031 Reset values: out_valid=0, busy=0, done=0, e_start=0, inv_o=0, addr_a=0, addr_b=0, n=0, stage=0.
REQ-032 A transform interrupted by reset SHALL not resume; the next start begins at stage 0, j=0.

Verification (LOG2N=5, STAGE_GAP=2 unless noted)
REQ-033 start pulse, out_ready=1 -> next cycle out_valid=1, stage=0, addr_a=0, addr_b=1, n=0, e_start=1; 80 transfers; 2-cycle gaps between stages; done one cycle after transfer 80.
REQ-034 Stage 4, j=5 -> addr_a=5, addr_b=21, n=5; stage 2, j=5 -> addr_a=9, addr_b=13, n=4; stage 1, j=3 -> addr_a=5, addr_b=7, n=8.
REQ-035 out_ready held low 4 cycles at stage 1, j=2 -> outputs frozen (addr_a=4, addr_b=6, n=0); sequence resumes at j=3 with no skip or repeat.
REQ-036 reset=0 during stage 3 -> next cycle all outputs at reset values; a following start begins at stage 0, j=0.
REQ-037 STAGE_GAP=0 -> stage 0 j=15 followed immediately by stage 1 j=0 (e_start=1), no out_valid gap.
REQ-038 start=1, inv=1 while busy -> ignored; inv_o keeps the value latched at acceptance until the next accepted start.
